// File: rtl/fp_posit_mac_ctrl.sv
// fp_posit_mac_ctrl
// Sequencer for the fp_posit_mul bit-serial multiplier. It accepts
// (FP16 activation, packed posit weight) pairs and programs the multiplier
// precision with a one-cycle set pulse. It streams the weight MSB-first,
// waits for the multiplier's done and then offers the product to the
// accumulator. Each product carries a last-element marker for its vector.
//
// Optional feature: define FPM_WATCHDOG_EN to bound the wait for mul_done to
// TIMEOUT cycles. On expiry a zero product is forced and the sticky wdog_err
// output is raised.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cfg_set/precision/vec_len, cfg_ready   configuration strobe and fields
//   in_valid/in_ready/in_act/in_wgt        operand pair handshake
//   mul_act/mul_w/mul_valid/mul_set/mul_precision  multiplier drive
//   mul_sign/mul_exp/mul_man/mul_done      multiplier result
//   out_valid/out_ready/out_sign/out_exp/out_man/out_last  product handshake
//   cfg_err             sticky illegal-configuration flag
//   wdog_err            sticky watchdog flag (FPM_WATCHDOG_EN only)
module fp_posit_mac_ctrl #(
    parameter int ACT_WIDTH = 16,
    parameter int MAX_W     = 8,
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FPM_WATCHDOG_EN
    output logic                 wdog_err,
`endif
    input  logic                 cfg_set,
    input  logic [3:0]           cfg_precision,
    input  logic [CNT_WIDTH-1:0] cfg_vec_len,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [MAX_W-1:0]     in_wgt,
    output logic [ACT_WIDTH-1:0] mul_act,
    output logic                 mul_w,
    output logic                 mul_valid,
    output logic                 mul_set,
    output logic [3:0]           mul_precision,
    input  logic                 mul_sign,
    input  logic [4:0]           mul_exp,
    input  logic [13:0]          mul_man,
    input  logic                 mul_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [4:0]           out_exp,
    output logic [13:0]          out_man,
    output logic                 out_last,
    output logic                 cfg_err
);

    if (MAX_W < 2 || MAX_W > 15 || TIMEOUT < 1) begin : g_param_check
        $error("fp_posit_mac_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_SHIFT, S_WAIT, S_OUT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [3:0]             prec_q, prec_d;
    logic [CNT_WIDTH-1:0]   vec_len_q, vec_len_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [ACT_WIDTH-1:0]   act_q, act_d;
    logic [MAX_W-1:0]       wgt_q, wgt_d;
    logic [3:0]             bits_q, bits_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   in_ready_q, in_ready_d;
    logic                   mul_w_q, mul_w_d;
    logic                   mul_valid_q, mul_valid_d;
    logic                   mul_set_q, mul_set_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sign_q, out_sign_d;
    logic [4:0]             out_exp_q, out_exp_d;
    logic [13:0]            out_man_q, out_man_d;
    logic                   out_last_q, out_last_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [7:0]             shamt;
    logic [MAX_W-1:0]       wgt_aligned;
    logic                   last_hit;
    logic                   cfg_legal;
`ifdef FPM_WATCHDOG_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic                   wdog_q, wdog_d;
`endif

    always_comb begin
        state_d     = state_q;
        prec_d      = prec_q;
        vec_len_d   = vec_len_q;
        count_d     = count_q;
        act_d       = act_q;
        wgt_d       = wgt_q;
        bits_d      = bits_q;
        cfg_ready_d = cfg_ready_q;
        in_ready_d  = in_ready_q;
        mul_w_d     = mul_w_q;
        mul_valid_d = mul_valid_q;
        mul_set_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_last_d  = out_last_q;
        cfg_err_d   = cfg_err_q;
        // Left-justify the right-aligned weight so the posit MSB sits at the top bit.
        shamt       = 8'(MAX_W) - {4'b0000, prec_q};
        wgt_aligned = in_wgt << shamt;
        last_hit    = (count_q + CNT_ONE) == vec_len_q;
        cfg_legal   = (cfg_precision >= 4'd2) && ({1'b0, cfg_precision} <= 5'(MAX_W));
`ifdef FPM_WATCHDOG_EN
        wcnt_d      = wcnt_q;
        wdog_d      = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Handshakes are qualified by the registered readies so nothing is
                // taken in the cycle right after reset release.
                if (cfg_set && cfg_ready_q) begin
                    if (cfg_legal) begin
                        prec_d      = cfg_precision;
                        vec_len_d   = (cfg_vec_len == '0) ? CNT_ONE : cfg_vec_len;
                        mul_set_d   = 1'b1;
                        cfg_ready_d = 1'b0;
                        in_ready_d  = 1'b0;
                        state_d     = S_CONFIG;
                    end else begin
                        cfg_err_d   = 1'b1;
                    end
                end else if (in_valid && in_ready_q) begin
                    act_d       = in_act;
                    mul_w_d     = wgt_aligned[MAX_W-1];
                    wgt_d       = wgt_aligned << 1;
                    bits_d      = prec_q - 4'd1;
                    mul_valid_d = 1'b1;
                    cfg_ready_d = 1'b0;
                    in_ready_d  = 1'b0;
                    state_d     = S_SHIFT;
                end else begin
                    cfg_ready_d = 1'b1;
                    in_ready_d  = 1'b1;
                end
            end
            S_CONFIG: begin
                count_d     = '0;
                cfg_ready_d = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
            S_SHIFT: begin
                // bits_q counts the bits still to send after the one on mul_w now.
                if (bits_q == 4'd0) begin
                    mul_valid_d = 1'b0;
                    mul_w_d     = 1'b0;
                    state_d     = S_WAIT;
`ifdef FPM_WATCHDOG_EN
                    wcnt_d      = '0;
`endif
                end else begin
                    mul_w_d = wgt_q[MAX_W-1];
                    wgt_d   = wgt_q << 1;
                    bits_d  = bits_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    out_sign_d  = mul_sign;
                    out_exp_d   = mul_exp;
                    out_man_d   = mul_man;
                    out_last_d  = last_hit;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
`ifdef FPM_WATCHDOG_EN
                else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    // Hand the accumulator a zero product so the vector still completes.
                    out_sign_d  = 1'b0;
                    out_exp_d   = '0;
                    out_man_d   = '0;
                    out_last_d  = last_hit;
                    out_valid_d = 1'b1;
                    wdog_d      = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = out_last_q ? '0 : count_q + CNT_ONE;
                    cfg_ready_d = 1'b1;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        wgt_q  <= wgt_d;
        bits_q <= bits_d;
`ifdef FPM_WATCHDOG_EN
        wcnt_q <= wcnt_d;
`endif
        if (!rst) begin
            state_q     <= S_IDLE;
            prec_q      <= 4'd4;
            vec_len_q   <= CNT_ONE;
            count_q     <= '0;
            act_q       <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            mul_w_q     <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_set_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef FPM_WATCHDOG_EN
            wdog_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            vec_len_q   <= vec_len_d;
            count_q     <= count_d;
            act_q       <= act_d;
            cfg_ready_q <= cfg_ready_d;
            in_ready_q  <= in_ready_d;
            mul_w_q     <= mul_w_d;
            mul_valid_q <= mul_valid_d;
            mul_set_q   <= mul_set_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_last_q  <= out_last_d;
            cfg_err_q   <= cfg_err_d;
`ifdef FPM_WATCHDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign in_ready      = in_ready_q;
    assign mul_act       = act_q;
    assign mul_w         = mul_w_q;
    assign mul_valid     = mul_valid_q;
    assign mul_set       = mul_set_q;
    assign mul_precision = prec_q;
    assign out_valid     = out_valid_q;
    assign out_sign      = out_sign_q;
    assign out_exp       = out_exp_q;
    assign out_man       = out_man_q;
    assign out_last      = out_last_q;
    assign cfg_err       = cfg_err_q;
`ifdef FPM_WATCHDOG_EN
    assign wdog_err      = wdog_q;
`endif

endmodule
